// File: rtl/divider_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : divider_unit_pkg
//  Brief    : Shared pipeline types and defaults for the iterative divider.
//  Revision : 1.0
// ============================================================================
package divider_unit_pkg;

    localparam int DIV_XLEN = 64;
    localparam int DIV_WLEN = 32;

    typedef enum logic {
        DIVOP = 1'b0,
        MODOP = 1'b1
    } divider_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/divider_unit.sv
`default_nettype none
// ============================================================================
//  Module   : divider_unit
//  Brief    : Radix-2 restoring integer divider, one quotient bit per cycle,
//             with word mode, signed operands and RISC-V style corner cases.
//  Revision : 1.0
// ============================================================================
module divider_unit
    import divider_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN,
    parameter int WLEN = DIV_WLEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  divider_op_t       op,
    input  logic              is_signed,
    input  logic              is_word,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   result,
    output logic              busy
);

    localparam int c_cnt_w = $clog2(XLEN + 1);
    localparam int c_shift = XLEN - WLEN;

    localparam logic [c_cnt_w-1:0] c_n_x     = c_cnt_w'(XLEN);
    localparam logic [c_cnt_w-1:0] c_n_w     = c_cnt_w'(WLEN);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [XLEN-1:0]    c_min_x   = XLEN'(1) << (XLEN - 1);
    localparam logic [XLEN-1:0]    c_min_w   = ~((XLEN'(1) << (WLEN - 1)) - XLEN'(1));

    // Narrow to the effective width, then widen back to XLEN.
    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] x,
                                               input logic word,
                                               input logic sgn);
        if (!word)
            return x;
        if (sgn)
            return XLEN'($signed(x << c_shift) >>> c_shift);
        return (x << c_shift) >> c_shift;
    endfunction

    div_state_t        r_state;
    logic              r_out_valid;
    logic [XLEN-1:0]   r_result;
    logic [c_cnt_w-1:0] r_cnt;
    divider_op_t       r_op;
    logic              r_signed;
    logic              r_word;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_quo;

    // Corner-case detection on the request being presented.
    logic [XLEN-1:0]   w_ea;
    logic [XLEN-1:0]   w_eb;
    logic              w_dbz;
    logic              w_ovf;
    logic [XLEN-1:0]   w_spec_sel;
    logic [XLEN-1:0]   w_spec_res;

    assign w_ea       = extend(a, is_word, is_signed);
    assign w_eb       = extend(b, is_word, is_signed);
    assign w_dbz      = (w_eb == '0);
    assign w_ovf      = is_signed && (&w_eb) && (w_ea == (is_word ? c_min_w : c_min_x));
    assign w_spec_sel = (op == MODOP) ? (w_dbz ? w_ea : '0) : (w_dbz ? '1 : w_ea);
    assign w_spec_res = extend(w_spec_sel, is_word, 1'b1);

    // Iteration datapath works on magnitudes of the latched operands.
    logic [XLEN-1:0]   w_la_ext;
    logic [XLEN-1:0]   w_lb_ext;
    logic              w_la_neg;
    logic              w_lb_neg;
    logic [XLEN-1:0]   w_la_mag;
    logic [XLEN-1:0]   w_div;
    logic              w_first;
    logic [XLEN-1:0]   w_dvd;
    logic [XLEN-1:0]   w_rem_cur;
    logic [XLEN:0]     w_trial;
    logic              w_ge;
    logic [XLEN-1:0]   w_rem_nx;
    logic [XLEN-1:0]   w_quo_nx;
    logic [XLEN-1:0]   w_q_fin;
    logic [XLEN-1:0]   w_r_fin;
    logic [XLEN-1:0]   w_fin_sel;
    logic [XLEN-1:0]   w_fin_res;

    assign w_la_ext  = extend(r_a, r_word, r_signed);
    assign w_lb_ext  = extend(r_b, r_word, r_signed);
    assign w_la_neg  = r_signed & w_la_ext[XLEN-1];
    assign w_lb_neg  = r_signed & w_lb_ext[XLEN-1];
    assign w_la_mag  = w_la_neg ? -w_la_ext : w_la_ext;
    assign w_div     = w_lb_neg ? -w_lb_ext : w_lb_ext;

    // The first CALC cycle seeds the shifter with the left-aligned dividend.
    assign w_first   = (r_cnt == (r_word ? c_n_w : c_n_x));
    assign w_dvd     = w_first ? (r_word ? (w_la_mag << c_shift) : w_la_mag) : r_quo;
    assign w_rem_cur = w_first ? '0 : r_rem;

    assign w_trial   = {w_rem_cur, w_dvd[XLEN-1]};
    assign w_ge      = (w_trial >= {1'b0, w_div});
    assign w_rem_nx  = w_ge ? XLEN'(w_trial - {1'b0, w_div}) : w_trial[XLEN-1:0];
    assign w_quo_nx  = {w_dvd[XLEN-2:0], w_ge};

    assign w_q_fin   = (w_la_neg ^ w_lb_neg) ? -w_quo_nx : w_quo_nx;
    assign w_r_fin   = w_la_neg ? -w_rem_nx : w_rem_nx;
    assign w_fin_sel = (r_op == MODOP) ? w_r_fin : w_q_fin;
    assign w_fin_res = extend(w_fin_sel, r_word, 1'b1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_cnt       <= '0;
            r_op        <= DIVOP;
            r_signed    <= 1'b0;
            r_word      <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
        end else if (flush) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op     <= op;
                        r_signed <= is_signed;
                        r_word   <= is_word;
                        r_a      <= a;
                        r_b      <= b;
                        if (w_dbz || w_ovf) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b1;
                            r_result    <= w_spec_res;
                        end else begin
                            r_state <= CALC;
                            r_cnt   <= is_word ? c_n_w : c_n_x;
                        end
                    end
                end
                CALC: begin
                    r_rem <= w_rem_nx;
                    r_quo <= w_quo_nx;
                    r_cnt <= r_cnt - c_cnt_one;
                    if (r_cnt == c_cnt_one) begin
                        r_state     <= DONE;
                        r_out_valid <= 1'b1;
                        r_result    <= w_fin_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_result    <= '0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_result    <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !flush;
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_divider_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_divider_unit
//  Brief    : Self-checking bench for divider_unit: arithmetic reference model
//             compared every cycle, plus directed literal cases.
//  Revision : 1.0
// ============================================================================
module tb_divider_unit;
    import divider_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    divider_op_t op = DIVOP;
    logic        is_signed = 1'b0;
    logic        is_word = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        busy;

    int total = 0;
    int bad   = 0;

    divider_unit #(.XLEN(64), .WLEN(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .is_signed (is_signed),
        .is_word   (is_word),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] eff(input logic [63:0] x, input bit word, input bit sgn);
        if (!word) return x;
        return sgn ? {{32{x[31]}}, x[31:0]} : {32'b0, x[31:0]};
    endfunction

    function automatic bit is_special(input bit sgn, input bit word,
                                      input logic [63:0] x, input logic [63:0] y);
        logic [63:0] ea, eb;
        ea = eff(x, word, sgn);
        eb = eff(y, word, sgn);
        if (eb == 64'd0) return 1'b1;
        return sgn && (eb == '1) && (ea == (word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    endfunction

    function automatic logic [63:0] ref_div(input divider_op_t o, input bit sgn, input bit word,
                                            input logic [63:0] x, input logic [63:0] y);
        logic [63:0] ea, eb, q, r, res;
        ea = eff(x, word, sgn);
        eb = eff(y, word, sgn);
        if (eb == 64'd0) begin
            q = '1;
            r = ea;
        end else if (is_special(sgn, word, x, y)) begin
            q = ea;
            r = '0;
        end else if (sgn) begin
            q = $signed(ea) / $signed(eb);
            r = $signed(ea) % $signed(eb);
        end else begin
            q = ea / eb;
            r = ea % eb;
        end
        res = (o == MODOP) ? r : q;
        if (word) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    // Transaction-level model: one outstanding request, result after latency.
    bit          m_busy = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left = 0;
    logic [63:0] m_res = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0; m_valid = 1'b0; m_left = 0; m_res = '0;
        end else if (flush) begin
            m_busy = 1'b0; m_valid = 1'b0; m_left = 0; m_res = '0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1'b1;
                m_res  = ref_div(op, is_signed, is_word, a, b);
                if (is_special(is_signed, is_word, a, b)) m_valid = 1'b1;
                else m_left = is_word ? 32 : 64;
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (out_ready) begin
            m_busy = 1'b0; m_valid = 1'b0; m_res = '0;
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 64'(out_valid), 64'(m_valid));
        chk("result", result, m_valid ? m_res : 64'd0);
        chk("busy", 64'(busy), 64'(m_busy));
        chk("in_ready", 64'(in_ready), 64'(!m_busy && !flush));
    end

    task automatic run_op(input divider_op_t o, input bit sgn, input bit word,
                          input logic [63:0] x, input logic [63:0] y,
                          input logic [63:0] exp, input int lat, input int hold);
        int n;
        @(posedge clk); #1;
        op = o; is_signed = sgn; is_word = word; a = x; b = y;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 200);
        chk("latency", 64'(n), 64'(lat));
        chk("value", result, exp);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_value", result, exp);
            chk("hold_in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after", 64'(busy), 64'd0);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
    endtask

    initial begin
        int pulses;
        int cat;
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_result", result, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        run_op(DIVOP, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65, 0);
        run_op(MODOP, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, 0);
        run_op(DIVOP, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, 0);
        run_op(DIVOP, 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 1, 0);
        run_op(DIVOP, 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0);
        run_op(MODOP, 1'b0, 1'b0, 64'd5, 64'd0, 64'd5, 1, 0);
        run_op(DIVOP, 1'b0, 1'b1, 64'hDEAD_0000_0000_0064, 64'hBEEF_0000_0000_0007, 64'd14, 33, 0);
        run_op(MODOP, 1'b1, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33, 0);
        run_op(DIVOP, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1, 0);
        run_op(DIVOP, 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 65, 5);

        // Flush during the 10th CALC cycle.
        @(posedge clk); #1;
        op = DIVOP; is_signed = 1'b0; is_word = 1'b0; a = 64'd1000000; b = 64'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", 64'(busy), 64'd0);
        count_pulses(80, pulses);
        chk("flush_no_pulse", 64'(pulses), 64'd0);
        run_op(DIVOP, 1'b0, 1'b0, 64'd9, 64'd3, 64'd3, 65, 0);

        // Reset mid-CALC.
        @(posedge clk); #1;
        op = DIVOP; a = 64'd12345; b = 64'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_calc_busy", 64'(busy), 64'd0);
        chk("rst_calc_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        count_pulses(80, pulses);
        chk("rst_calc_no_pulse", 64'(pulses), 64'd0);

        // Reset mid-DONE.
        @(posedge clk); #1;
        op = MODOP; a = 64'd77; b = 64'd0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        chk("rst_done_valid", 64'(out_valid), 64'd0);
        chk("rst_done_result", result, 64'd0);
        @(posedge clk);
        #3 reset = 1'b0;
        count_pulses(10, pulses);
        chk("rst_done_no_pulse", 64'(pulses), 64'd0);

        // Randomized traffic; the compare process checks every cycle.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 2) != 0);
            op        = $urandom_range(0, 1) ? MODOP : DIVOP;
            is_signed = $urandom_range(0, 1);
            is_word   = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 299) == 0);
            cat       = $urandom_range(0, 5);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case (cat)
                1: begin a = 64'($urandom_range(0, 40)); b = 64'($urandom_range(0, 9)); end
                2: b = is_word ? {$urandom, 32'd0} : 64'd0;
                3: begin
                    a = is_word ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    b = is_word ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
                end
                4: b = 64'($urandom_range(1, 300));
                5: b = {32'hFFFF_FFFF, 32'($urandom_range(0, 65535)) | 32'hFFFF_0000};
                default: ;
            endcase
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (5) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divider_unit.md
DIVIDER_UNIT -- requirements
Module: divider_unit

Interface
REQ-001 Parameter XLEN, default 64, full datapath width in bits.
REQ-002 Parameter WLEN, default 32, word-mode width in bits; SHALL be less than or equal to XLEN.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 in_valid  in  1  request present.
REQ-007 in_ready  out  1  block can accept a request.
REQ-008 op  in  divider_op_t  DIVOP gives quotient, MODOP gives remainder.
REQ-009 is_signed  in  1  two's-complement operands.
REQ-010 is_word  in  1  WLEN-bit operation.
REQ-011 a  in  XLEN  dividend.
REQ-012 b  in  XLEN  divisor.
REQ-013 flush  in  1  abandon any in-flight operation.
REQ-014 out_valid  out  1  result present.
REQ-015 out_ready  in  1  consumer takes the result.
REQ-016 result  out  XLEN  quotient or remainder.
REQ-017 busy  out  1  state is not IDLE.

Function
REQ-018 The state machine SHALL have states IDLE, CALC and DONE; in_ready SHALL be 1 only when the state is IDLE and flush is 0.
REQ-019 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1; on acceptance, op, is_signed, is_word, a and b SHALL be latched.
REQ-020 Word mode SHALL use a[WLEN-1:0] and b[WLEN-1:0], sign-extended when is_signed is 1 and zero-extended otherwise; the iteration count N SHALL be WLEN in word mode and XLEN otherwise.
REQ-021 The divider SHALL be radix-2 restoring, one quotient bit per CALC cycle, operating on operand magnitudes.
- Quotient sign = sign(a) XOR sign(b).
- Remainder sign = sign(a).
REQ-022 For a normal request, the block SHALL spend N cycles in CALC, then enter DONE; out_valid SHALL first be 1 exactly N+1 cycles after the accepting edge.
REQ-023 Divide by zero (divisor equal to 0 in the effective width) SHALL skip CALC and enter DONE on the accepting edge.
- Quotient = all ones in the effective width.
- Remainder = effective dividend.
REQ-024 Signed overflow (most-negative dividend divided by -1) SHALL skip CALC and enter DONE on the accepting edge.
- Quotient = the dividend.
- Remainder = 0.
REQ-025 In word mode, the WLEN-bit result SHALL be sign-extended to XLEN regardless of is_signed.
REQ-026 In DONE, out_valid SHALL be 1 and result SHALL remain stable until out_ready is 1; the state SHALL then return to IDLE on that edge.
REQ-027 There SHALL be no back-to-back acceptance; a new request is accepted no earlier than the cycle after the DONE handshake.
REQ-028 flush SHALL have priority over every other event: the next state SHALL be IDLE, the result SHALL be discarded, and a request presented in the same cycle SHALL NOT be accepted.
REQ-029 When out_valid is 0, result SHALL be 0.

Reset
REQ-030 While reset is 1, state SHALL be IDLE, out_valid SHALL be 0, result SHALL be 0, busy SHALL be 0, and the iteration counter and all latched operands SHALL be 0, independent of clk.
REQ-031 Reset asserted mid-CALC or mid-DONE SHALL abandon the operation; no out_valid pulse SHALL follow the release of reset.

Structure
REQ-032 divider_op_t SHALL remain in the shared pipeline package.
REQ-033 The state enum div_state_t (IDLE, CALC, DONE) and the defaults DIV_XLEN=64 and DIV_WLEN=32 SHALL be added to the shared pipeline package.
REQ-034 The block SHALL be a single module; no sub-module is required, and the counter width SHALL be $clog2(XLEN+1).

Verification
REQ-035 Unsigned 64-bit DIVOP: a=100, b=7 -> result=14, with out_valid 65 cycles after acceptance.
REQ-036 Signed MODOP: a=-7, b=2 -> result=0xFFFF_FFFF_FFFF_FFFF; signed DIVOP with the same operands -> result=0xFFFF_FFFF_FFFF_FFFD.
REQ-037 Word signed DIVOP: a=0x0000_0000_8000_0000, b=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_8000_0000, with out_valid 1 cycle after acceptance.
REQ-038 Divide by zero: unsigned DIVOP a=5, b=0 -> result=0xFFFF_FFFF_FFFF_FFFF; MODOP with the same operands -> result=5, each 1 cycle after acceptance.
REQ-039 flush during the 10th CALC cycle -> busy=0 on the next cycle, no out_valid pulse, and a following request (a=9, b=3) returns result=3.
REQ-040 out_ready held 0 for 5 cycles in DONE -> out_valid and result stay stable, in_ready stays 0, and IDLE is reached on the edge where out_ready is 1.
